// File: rtl/johnson_seq_pkg.sv
// Shared types and Johnson-code helpers for the ring sequencer.
// Helpers take the ring width at run time so one package serves every WIDTH up to MAX_W.
package johnson_seq_pkg;

   localparam int MAX_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WAIT_STEP,
      DONE
   } seq_state_e;

   // Code k of a w-stage ring: k low ones while filling, then ones draining from the bottom.
   function automatic logic [MAX_W-1:0] johnson_code(input int w, input int k);
      logic [MAX_W-1:0] c;
      c = '0;
      for (int b = 0; b < MAX_W; b++) begin
         if (k <= w) c[b] = (b < k);
         else        c[b] = (b >= k - w) && (b < w);
      end
      return c;
   endfunction

   function automatic logic [2*MAX_W-1:0] johnson_phase(input logic [MAX_W-1:0] q, input int w);
      logic [2*MAX_W-1:0] ph;
      ph = '0;
      for (int k = 0; k < 2*MAX_W; k++) begin
         if (k < 2*w && q == johnson_code(w, k)) ph[k] = 1'b1;
      end
      return ph;
   endfunction

   function automatic logic is_legal_johnson(input logic [MAX_W-1:0] q, input int w);
      return |johnson_phase(q, w);
   endfunction

endpackage

// File: rtl/johnson_ring.sv
// WIDTH-stage twisted-ring register with clear, parallel load and advance.
// Priority: i_srst > clr > ld > en.
module johnson_ring #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_srst,
   input  logic             en,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge i_clk) begin
      if (i_srst)      q <= '0;
      else if (clr)    q <= '0;
      else if (ld)     q <= ld_val;
      else if (en)     q <= {q[WIDTH-2:0], ~q[WIDTH-1]};
   end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequencer that runs a Johnson ring for a programmed number of advances,
// free-running or on request, and resynchronises the ring on illegal codes.
module johnson_seq_ctrl
   import johnson_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic               i_clk,
   input  logic               i_srst,
   input  logic               i_start,
   input  logic [CNT_W-1:0]   i_steps,
   input  logic               i_mode,
   input  logic               i_step_req,
   input  logic               i_abort,
   input  logic               i_load,
   input  logic [WIDTH-1:0]   i_load_val,
   output logic [WIDTH-1:0]   o_q,
   output logic [2*WIDTH-1:0] o_phase,
   output logic               o_busy,
   output logic               o_done,
   output logic [CNT_W-1:0]   o_remaining,
   output logic               o_err
);

   seq_state_e       state, next_state;
   logic [CNT_W-1:0] remaining;
   logic             err;
   logic [WIDTH-1:0] q;
   logic             illegal, start_ok, advance, ring_ld;

   johnson_ring #(.WIDTH(WIDTH)) u_ring (
      .i_clk  (i_clk),
      .i_srst (i_srst),
      .en     (advance),
      .clr    (illegal),
      .ld     (ring_ld),
      .ld_val (i_load_val),
      .q      (q)
   );

   // An illegal ring code blocks every other action in the same cycle.
   always_comb begin
      illegal  = !is_legal_johnson(MAX_W'(q), WIDTH);
      start_ok = (state == IDLE) && i_start && !illegal;
      ring_ld  = (state == IDLE) && i_load && !i_start && !illegal;
      advance  = !illegal && !i_abort && (remaining != '0) &&
                 ((state == RUN) || ((state == WAIT_STEP) && i_step_req));
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start_ok) begin
               if (i_steps == '0) next_state = DONE;
               else if (i_mode)   next_state = WAIT_STEP;
               else               next_state = RUN;
            end
         end
         RUN, WAIT_STEP: begin
            if (illegal || i_abort || remaining == '0)          next_state = DONE;
            else if (advance && remaining == CNT_W'(1))         next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Step counter and sticky error; a fresh run clears the error.
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         remaining <= '0;
         err       <= 1'b0;
      end else begin
         if (illegal)       err <= 1'b1;
         else if (start_ok) err <= 1'b0;
         if (start_ok)      remaining <= i_steps;
         else if (advance)  remaining <= remaining - CNT_W'(1);
      end
   end

   always_comb begin
      o_q         = q;
      o_phase     = (2*WIDTH)'(johnson_phase(MAX_W'(q), WIDTH));
      o_busy      = (state == RUN) || (state == WAIT_STEP);
      o_done      = (state == DONE);
      o_remaining = remaining;
      o_err       = err;
   end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench: behavioural ring model from the code table, directed runs plus random traffic.
module tb_johnson_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;
   localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_DONE = 3;

   logic             clk = 1'b0;
   logic             srst, start, mode, step_req, abort, load;
   logic [CNT_W-1:0] steps;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [2*WIDTH-1:0] phase;
   logic             busy, done, err;
   logic [CNT_W-1:0] remaining;

   int n_vec  = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   logic [3:0] seq_tab [8];
   logic [3:0] m_q;
   int         m_rem;
   int         m_st;
   bit         m_err;

   always #5 clk = ~clk;

   johnson_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clk       (clk),
      .i_srst      (srst),
      .i_start     (start),
      .i_steps     (steps),
      .i_mode      (mode),
      .i_step_req  (step_req),
      .i_abort     (abort),
      .i_load      (load),
      .i_load_val  (load_val),
      .o_q         (q),
      .o_phase     (phase),
      .o_busy      (busy),
      .o_done      (done),
      .o_remaining (remaining),
      .o_err       (err)
   );

   function automatic int seq_index(input logic [3:0] v);
      for (int k = 0; k < 8; k++) if (seq_tab[k] == v) return k;
      return -1;
   endfunction

   function automatic logic [7:0] exp_phase(input logic [3:0] v);
      int idx;
      idx = seq_index(v);
      if (idx < 0) return 8'h00;
      return 8'(1) << idx;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      checkValue("q",         32'(q),         32'(m_q));
      checkValue("phase",     32'(phase),     32'(exp_phase(m_q)));
      checkValue("busy",      32'(busy),      32'(m_st == M_RUN || m_st == M_WAIT));
      checkValue("done",      32'(done),      32'(m_st == M_DONE));
      checkValue("remaining", 32'(remaining), 32'(m_rem));
      checkValue("err",       32'(err),       32'(m_err));
   endtask

   // Model one clock edge from the rules, using the inputs currently applied.
   task automatic modelStep();
      if (srst) begin
         m_st = M_IDLE; m_q = 4'b0000; m_rem = 0; m_err = 1'b0;
      end else if (seq_index(m_q) < 0) begin
         m_err = 1'b1;
         m_q   = 4'b0000;
         if (m_st == M_RUN || m_st == M_WAIT || m_st == M_DONE)
            m_st = (m_st == M_DONE) ? M_IDLE : M_DONE;
      end else begin
         case (m_st)
            M_IDLE: begin
               if (start) begin
                  m_err = 1'b0;
                  m_rem = int'(steps);
                  m_st  = (steps == 0) ? M_DONE : (mode ? M_WAIT : M_RUN);
               end else if (load) begin
                  m_q = load_val;
               end
            end
            M_RUN, M_WAIT: begin
               if (abort) m_st = M_DONE;
               else if (m_st == M_RUN || step_req) begin
                  m_q   = seq_tab[(seq_index(m_q) + 1) % 8];
                  m_rem = m_rem - 1;
                  if (m_rem == 0) m_st = M_DONE;
               end
            end
            default: m_st = M_IDLE;
         endcase
      end
   endtask

   task automatic applyStimulus(input bit s_srst, input bit s_start, input logic [7:0] s_steps,
                                input bit s_mode, input bit s_req, input bit s_abort,
                                input bit s_load, input logic [3:0] s_lval);
      @(negedge clk);
      #1;
      srst = s_srst; start = s_start; steps = s_steps; mode = s_mode;
      step_req = s_req; abort = s_abort; load = s_load; load_val = s_lval;
      @(posedge clk);
      #1;
      modelStep();
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(0, 0, 8'd0, 0, 0, 0, 0, 4'h0);
   endtask

   task automatic waitForDone(input int bound, output int cycles);
      cycles = 0;
      while (!done && cycles < bound) begin
         idleCycles(1);
         cycles++;
      end
      if (!done) checkValue("done_timeout", 32'(done), 32'(1));
   endtask

   always @(negedge clk) if (check_en) checkOutput();

   initial begin
      int c;
      seq_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      srst = 1'b1; start = 0; steps = '0; mode = 0; step_req = 0; abort = 0; load = 0; load_val = '0;
      m_st = M_IDLE; m_q = 4'b0000; m_rem = 0; m_err = 1'b0;

      applyStimulus(1, 0, 8'd0, 0, 0, 0, 0, 4'h0);
      check_en = 1'b1;
      applyStimulus(1, 0, 8'd0, 0, 0, 0, 0, 4'h0);
      checkValue("rst_q",     32'(q),     32'(4'b0000));
      checkValue("rst_phase", 32'(phase), 32'(8'b00000001));
      checkValue("rst_busy",  32'(busy),  32'(0));
      checkValue("rst_done",  32'(done),  32'(0));
      checkValue("rst_err",   32'(err),   32'(0));

      // Free-run, three steps
      applyStimulus(0, 1, 8'd3, 0, 0, 0, 0, 4'h0);
      checkValue("run3_busy", 32'(busy), 32'(1));
      idleCycles(1); checkValue("run3_q1", 32'(q), 32'(4'b0001));
      idleCycles(1); checkValue("run3_q2", 32'(q), 32'(4'b0011));
      idleCycles(1); checkValue("run3_q3", 32'(q), 32'(4'b0111));
      checkValue("run3_done", 32'(done), 32'(1));
      checkValue("run3_rem",  32'(remaining), 32'(0));
      idleCycles(1); checkValue("run3_done_once", 32'(done), 32'(0));

      // Full wrap from 0000 after reloading the ring
      applyStimulus(0, 0, 8'd0, 0, 0, 0, 1, 4'b0000);
      applyStimulus(0, 1, 8'd8, 0, 0, 0, 0, 4'h0);
      idleCycles(1); checkValue("wrap_phase1", 32'(phase), 32'(8'b00000010));
      waitForDone(20, c);
      checkValue("wrap_latency", 32'(c), 32'(7));
      checkValue("wrap_q",     32'(q),     32'(4'b0000));
      checkValue("wrap_phase", 32'(phase), 32'(8'b00000001));
      idleCycles(1);
      applyStimulus(0, 1, 8'd0, 0, 0, 0, 0, 4'h0);
      checkValue("zero_done", 32'(done), 32'(1));
      checkValue("zero_q",    32'(q),    32'(4'b0000));
      idleCycles(1);

      // Single-step with gaps between requests
      applyStimulus(0, 1, 8'd2, 1, 0, 0, 0, 4'h0);
      idleCycles(1); checkValue("ss_hold_q", 32'(q), 32'(4'b0000));
      applyStimulus(0, 0, 8'd0, 0, 1, 0, 0, 4'h0);
      checkValue("ss_q1", 32'(q), 32'(4'b0001));
      idleCycles(2); checkValue("ss_busy", 32'(busy), 32'(1));
      applyStimulus(0, 0, 8'd0, 0, 1, 0, 0, 4'h0);
      checkValue("ss_q2",   32'(q),    32'(4'b0011));
      checkValue("ss_done", 32'(done), 32'(1));
      idleCycles(1);

      // Abort after four advances
      applyStimulus(0, 0, 8'd0, 0, 0, 0, 1, 4'b0000);
      applyStimulus(0, 1, 8'd10, 0, 0, 0, 0, 4'h0);
      idleCycles(4);
      checkValue("abort_pre_q", 32'(q), 32'(4'b1111));
      applyStimulus(0, 0, 8'd0, 0, 0, 1, 0, 4'h0);
      checkValue("abort_q",    32'(q),         32'(4'b1111));
      checkValue("abort_rem",  32'(remaining), 32'(6));
      checkValue("abort_done", 32'(done),      32'(1));
      idleCycles(1);

      // Illegal load, recovery, and reset mid-run
      applyStimulus(0, 0, 8'd0, 0, 0, 0, 1, 4'b0101);
      checkValue("ill_phase", 32'(phase), 32'(8'h00));
      idleCycles(1);
      checkValue("ill_err", 32'(err), 32'(1));
      checkValue("ill_q",   32'(q),   32'(4'b0000));
      applyStimulus(0, 1, 8'd2, 0, 0, 0, 0, 4'h0);
      checkValue("ill_err_clr", 32'(err), 32'(0));
      idleCycles(1);
      applyStimulus(1, 0, 8'd0, 0, 0, 0, 0, 4'h0);
      checkValue("srst_q",    32'(q),    32'(4'b0000));
      checkValue("srst_busy", 32'(busy), 32'(0));
      idleCycles(1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 63) == 0),
                       ($urandom_range(0, 5) == 0),
                       8'($urandom_range(0, 12)),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 7) == 0),
                       4'($urandom_range(0, 15)));
      end
      idleCycles(12);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
